// File: rtl/pipe_lsu.sv
// pipe_lsu: load/store stage between the execute stage and writeback.
//
// Takes one EXU result per handshake. Non-memory ops are registered straight
// into the result slot, so they have one cycle of latency. Aligned loads and
// stores each run one AXI-lite transaction. Misaligned accesses never reach
// the bus and come back with an error. The result register is also the
// forwarding source.
//
// State table:
//   IDLE  | ready for a new EXU result; no bus transaction open
//   RD_AR | load address on AR, waiting for arready
//   RD_R  | rready high, waiting for read data
//   WR    | AW and W presented; each channel drops after its own handshake
//   WR_B  | bready high, waiting for the write response
//
// Ports:
//   clk_i, rst_i                   clock; synchronous active-high reset
//   ex_*_i / lsu_ready_o           EXU result handshake and fields
//   lsu_valid_o, wb_ready_i        result handshake to WB
//   lsu_rd_o/rd_wen_o/data_o/err_o result fields
//   fwd_valid_o/rd_o/data_o        forwarding copy of the result register
//   lsu_ar*/r*/aw*/w*/b*           AXI-lite master channels
module pipe_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_valid_i,
  output logic                  lsu_ready_o,
  input  logic [3:0]            ex_op_i,
  input  logic [ADDR_WIDTH-1:0] ex_addr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic [DATA_WIDTH-1:0] ex_result_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  ex_rd_wen_i,
  output logic                  lsu_valid_o,
  input  logic                  wb_ready_i,
  output logic [4:0]            lsu_rd_o,
  output logic                  lsu_rd_wen_o,
  output logic [DATA_WIDTH-1:0] lsu_data_o,
  output logic                  lsu_err_o,
  output logic                  fwd_valid_o,
  output logic [4:0]            fwd_rd_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic [ADDR_WIDTH-1:0] lsu_araddr_o,
  output logic                  lsu_arvalid_o,
  input  logic                  lsu_arready_i,
  input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
  input  logic                  lsu_rvalid_i,
  output logic                  lsu_rready_o,
  output logic [ADDR_WIDTH-1:0] lsu_awaddr_o,
  output logic                  lsu_awvalid_o,
  input  logic                  lsu_awready_i,
  output logic [DATA_WIDTH-1:0] lsu_wdata_o,
  output logic [STRB_WIDTH-1:0] lsu_wstrb_o,
  output logic                  lsu_wvalid_o,
  input  logic                  lsu_wready_i,
  input  logic [1:0]            lsu_bresp_i,
  input  logic                  lsu_bvalid_i,
  output logic                  lsu_bready_o
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_AR = 3'd1,
    RD_R  = 3'd2,
    WR    = 3'd3,
    WR_B  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [4:0]            rd_q;
  logic                  rd_wen_q;
  logic                  aw_done, w_done;
  logic                  aw_done_n, w_done_n;

  logic                  res_valid;
  logic [4:0]            res_rd;
  logic                  res_wen;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_err;

  logic accept;
  logic in_load, in_store, in_mis;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] load_data;

  // Decode of the incoming op; anything not listed behaves as a non-memory op.
  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    in_mis   = 1'b0;
    case (ex_op_i)
      OP_LB, OP_LBU: in_load = 1'b1;
      OP_LH, OP_LHU: begin in_load  = 1'b1; in_mis = ex_addr_i[0]; end
      OP_LW:         begin in_load  = 1'b1; in_mis = |ex_addr_i[1:0]; end
      OP_SB:         in_store = 1'b1;
      OP_SH:         begin in_store = 1'b1; in_mis = ex_addr_i[0]; end
      OP_SW:         begin in_store = 1'b1; in_mis = |ex_addr_i[1:0]; end
      default: ;
    endcase
  end

  assign lsu_ready_o = (state == IDLE) && (!res_valid || wb_ready_i);
  assign accept      = ex_valid_i && lsu_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    aw_done_n     = aw_done;
    w_done_n      = w_done;
    lsu_arvalid_o = 1'b0;
    lsu_rready_o  = 1'b0;
    lsu_awvalid_o = 1'b0;
    lsu_wvalid_o  = 1'b0;
    lsu_bready_o  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !in_mis) begin
          if (in_load)       state_n = RD_AR;
          else if (in_store) state_n = WR;
        end
      end
      RD_AR: begin
        lsu_arvalid_o = 1'b1;
        if (lsu_arready_i) state_n = RD_R;
      end
      RD_R: begin
        lsu_rready_o = 1'b1;
        if (lsu_rvalid_i) state_n = IDLE;
      end
      WR: begin
        lsu_awvalid_o = !aw_done;
        lsu_wvalid_o  = !w_done;
        aw_done_n     = aw_done || lsu_awready_i;
        w_done_n      = w_done || lsu_wready_i;
        if (aw_done_n && w_done_n) state_n = WR_B;
      end
      WR_B: begin
        lsu_bready_o = 1'b1;
        if (lsu_bvalid_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Aligned sub-word loads only ever need the lane shifted down to bit 0;
  // halves are aligned, so the byte-granular shift also serves LH/LHU.
  assign rd_shift = lsu_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (op_q)
      OP_LB:   load_data = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      OP_LH:   load_data = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      OP_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: load_data = lsu_rdata_i;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SB: begin
        lsu_wdata_o = {(DATA_WIDTH/8){wdata_q[7:0]}};
        lsu_wstrb_o = {{(STRB_WIDTH-1){1'b0}}, 1'b1} << addr_q[1:0];
      end
      OP_SH: begin
        lsu_wdata_o = {(DATA_WIDTH/16){wdata_q[15:0]}};
        lsu_wstrb_o = {{(STRB_WIDTH-2){1'b0}}, 2'b11} << addr_q[1:0];
      end
      OP_SW: begin
        lsu_wdata_o = wdata_q;
        lsu_wstrb_o = {STRB_WIDTH{1'b1}};
      end
      default: begin
        lsu_wdata_o = '0;
        lsu_wstrb_o = '0;
      end
    endcase
  end

  assign lsu_araddr_o = addr_q;
  assign lsu_awaddr_o = addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      if (accept) begin
        op_q     <= ex_op_i;
        addr_q   <= ex_addr_i;
        wdata_q  <= ex_wdata_i;
        rd_q     <= ex_rd_i;
        rd_wen_q <= ex_rd_wen_i;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
    end
  end

  // Result slot. Bus completions can load without checking wb_ready_i: the
  // slot was free or draining when the op was accepted, and nothing else can
  // be accepted while the transaction is open.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid <= 1'b0;
      res_rd    <= '0;
      res_wen   <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else if (accept && (in_mis || (!in_load && !in_store))) begin
      res_valid <= 1'b1;
      res_rd    <= ex_rd_i;
      res_wen   <= ex_rd_wen_i && !in_mis;
      res_data  <= in_mis ? '0 : ex_result_i;
      res_err   <= in_mis;
    end else if (state == RD_R && lsu_rvalid_i) begin
      res_valid <= 1'b1;
      res_rd    <= rd_q;
      res_wen   <= rd_wen_q;
      res_data  <= load_data;
      res_err   <= 1'b0;
    end else if (state == WR_B && lsu_bvalid_i) begin
      res_valid <= 1'b1;
      res_rd    <= rd_q;
      res_wen   <= 1'b0;
      res_data  <= '0;
      res_err   <= |lsu_bresp_i;
    end else if (wb_ready_i) begin
      res_valid <= 1'b0;
    end
  end

  assign lsu_valid_o  = res_valid;
  assign lsu_rd_o     = res_rd;
  assign lsu_rd_wen_o = res_wen;
  assign lsu_data_o   = res_data;
  assign lsu_err_o    = res_err;

  assign fwd_valid_o = res_valid && res_wen;
  assign fwd_rd_o    = res_rd;
  assign fwd_data_o  = res_data;

endmodule

// File: tb/tb_pipe_lsu.sv
// Directed bench for pipe_lsu: the bench plays EXU, WB and the AXI-lite slave.
module tb_pipe_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        lsu_ready_o;
  logic [3:0]  ex_op_i;
  logic [31:0] ex_addr_i, ex_wdata_i, ex_result_i;
  logic [4:0]  ex_rd_i;
  logic        ex_rd_wen_i;
  logic        lsu_valid_o, wb_ready_i;
  logic [4:0]  lsu_rd_o;
  logic        lsu_rd_wen_o;
  logic [31:0] lsu_data_o;
  logic        lsu_err_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
  logic [31:0] lsu_araddr_o;
  logic        lsu_arvalid_o, lsu_arready_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_rvalid_i, lsu_rready_o;
  logic [31:0] lsu_awaddr_o;
  logic        lsu_awvalid_o, lsu_awready_i;
  logic [31:0] lsu_wdata_o;
  logic [3:0]  lsu_wstrb_o;
  logic        lsu_wvalid_o, lsu_wready_i;
  logic [1:0]  lsu_bresp_i;
  logic        lsu_bvalid_i, lsu_bready_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  pipe_lsu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .lsu_ready_o(lsu_ready_o), .ex_op_i(ex_op_i),
    .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_result_i(ex_result_i),
    .ex_rd_i(ex_rd_i), .ex_rd_wen_i(ex_rd_wen_i),
    .lsu_valid_o(lsu_valid_o), .wb_ready_i(wb_ready_i),
    .lsu_rd_o(lsu_rd_o), .lsu_rd_wen_o(lsu_rd_wen_o), .lsu_data_o(lsu_data_o),
    .lsu_err_o(lsu_err_o),
    .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
    .lsu_araddr_o(lsu_araddr_o), .lsu_arvalid_o(lsu_arvalid_o), .lsu_arready_i(lsu_arready_i),
    .lsu_rdata_i(lsu_rdata_i), .lsu_rvalid_i(lsu_rvalid_i), .lsu_rready_o(lsu_rready_o),
    .lsu_awaddr_o(lsu_awaddr_o), .lsu_awvalid_o(lsu_awvalid_o), .lsu_awready_i(lsu_awready_i),
    .lsu_wdata_o(lsu_wdata_o), .lsu_wstrb_o(lsu_wstrb_o), .lsu_wvalid_o(lsu_wvalid_o),
    .lsu_wready_i(lsu_wready_i),
    .lsu_bresp_i(lsu_bresp_i), .lsu_bvalid_i(lsu_bvalid_i), .lsu_bready_o(lsu_bready_o)
  );

  // Presents one EXU result for a single edge; returns 1ns after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] result, input logic [4:0] rd, input logic wen);
    @(negedge clk_i);
    ex_op_i = op; ex_addr_i = addr; ex_wdata_i = wdata;
    ex_result_i = result; ex_rd_i = rd; ex_rd_wen_i = wen;
    ex_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    ex_valid_i = 1'b0;
    ex_op_i = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({lsu_valid_o, lsu_arvalid_o, lsu_rready_o, lsu_awvalid_o, lsu_wvalid_o, lsu_bready_o, fwd_valid_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b want 0000000",
               {lsu_valid_o, lsu_arvalid_o, lsu_rready_o, lsu_awvalid_o, lsu_wvalid_o, lsu_bready_o, fwd_valid_o});
    end
    n_checks++;
    if ({lsu_data_o, lsu_araddr_o, lsu_awaddr_o, lsu_wdata_o, lsu_wstrb_o} !== 132'b0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h araddr=%h awaddr=%h wdata=%h wstrb=%h want all 0",
               lsu_data_o, lsu_araddr_o, lsu_awaddr_o, lsu_wdata_o, lsu_wstrb_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", lsu_ready_o);
    end
  endtask

  task automatic test_passthrough;
    issue(4'b0000, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if ({lsu_valid_o, fwd_valid_o, lsu_rd_wen_o, lsu_err_o} !== 4'b1110 || lsu_data_o !== 32'h1234
        || lsu_rd_o !== 5'd5 || fwd_data_o !== 32'h1234 || fwd_rd_o !== 5'd5) begin
      n_fail++;
      $display("FAIL passthrough: v/fv/wen/err=%b data=%h rd=%0d fdata=%h frd=%0d want 1110 1234 5",
               {lsu_valid_o, fwd_valid_o, lsu_rd_wen_o, lsu_err_o}, lsu_data_o, lsu_rd_o, fwd_data_o, fwd_rd_o);
    end
    n_checks++;
    if (lsu_arvalid_o !== 1'b0 || lsu_awvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL passthrough_bus: arvalid=%b awvalid=%b want 0 0", lsu_arvalid_o, lsu_awvalid_o);
    end
    // Undefined op code acts like none.
    issue(4'b0111, 32'h0, 32'h0, 32'h5555_AAAA, 5'd9, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b1 || lsu_data_o !== 32'h5555_AAAA || lsu_arvalid_o !== 1'b0 || lsu_awvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL undefined_op: valid=%b data=%h arvalid=%b awvalid=%b want 1 5555aaaa 0 0",
               lsu_valid_o, lsu_data_o, lsu_arvalid_o, lsu_awvalid_o);
    end
    idle(1);
  endtask

  task automatic test_load(input string name, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
    issue(op, addr, 32'h0, 32'hDEAD_0000, 5'd12, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (lsu_arvalid_o !== 1'b1 || lsu_araddr_o !== addr || lsu_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ar: arvalid=%b araddr=%h ready=%b want 1 %h 0", name, lsu_arvalid_o, lsu_araddr_o, lsu_ready_o, addr);
    end
    lsu_arready_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_arready_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_arvalid_o !== 1'b0 || lsu_rready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_r: arvalid=%b rready=%b want 0 1", name, lsu_arvalid_o, lsu_rready_o);
    end
    lsu_rdata_i = word; lsu_rvalid_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_rvalid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b1 || lsu_data_o !== exp || lsu_rd_wen_o !== 1'b1 || lsu_err_o !== 1'b0
        || lsu_rd_o !== 5'd12 || lsu_rready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_result: valid=%b data=%h wen=%b err=%b rd=%0d rready=%b want 1 %h 1 0 12 0",
               name, lsu_valid_o, lsu_data_o, lsu_rd_wen_o, lsu_err_o, lsu_rd_o, lsu_rready_o, exp);
    end
    idle(1);
  endtask

  task automatic test_store_half;
    issue(4'b1010, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 5'd3, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (lsu_awvalid_o !== 1'b1 || lsu_wvalid_o !== 1'b1 || lsu_awaddr_o !== 32'h8000_0002
        || lsu_wdata_o !== 32'hABCD_ABCD || lsu_wstrb_o !== 4'b1100) begin
      n_fail++;
      $display("FAIL sh_bus: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b want 1 1 80000002 abcdabcd 1100",
               lsu_awvalid_o, lsu_wvalid_o, lsu_awaddr_o, lsu_wdata_o, lsu_wstrb_o);
    end
    lsu_awready_i = 1'b1; lsu_wready_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_awready_i = 1'b0; lsu_wready_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_awvalid_o !== 1'b0 || lsu_wvalid_o !== 1'b0 || lsu_bready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_b: awv=%b wv=%b bready=%b want 0 0 1", lsu_awvalid_o, lsu_wvalid_o, lsu_bready_o);
    end
    lsu_bresp_i = 2'b00; lsu_bvalid_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_bvalid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b1 || lsu_rd_wen_o !== 1'b0 || lsu_err_o !== 1'b0 || fwd_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_result: valid=%b wen=%b err=%b fwd=%b want 1 0 0 0", lsu_valid_o, lsu_rd_wen_o, lsu_err_o, fwd_valid_o);
    end
    idle(1);
  endtask

  task automatic test_store_byte;
    issue(4'b1001, 32'h8000_0001, 32'h0000_0077, 32'h0, 5'd3, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (lsu_wdata_o !== 32'h7777_7777 || lsu_wstrb_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL sb_bus: wdata=%h wstrb=%b want 77777777 0010", lsu_wdata_o, lsu_wstrb_o);
    end
    lsu_awready_i = 1'b1; lsu_wready_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_awready_i = 1'b0; lsu_wready_i = 1'b0;
    lsu_bresp_i = 2'b00; lsu_bvalid_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_bvalid_i = 1'b0;
    idle(2);
  endtask

  task automatic test_misaligned;
    int arv_seen;
    arv_seen = 0;
    issue(4'b0011, 32'h8000_0001, 32'h0, 32'h0, 5'd8, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_rd_wen_o !== 1'b0 || fwd_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_misaligned: valid=%b err=%b wen=%b fwd=%b want 1 1 0 0", lsu_valid_o, lsu_err_o, lsu_rd_wen_o, fwd_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (lsu_arvalid_o !== 1'b0) arv_seen++;
      @(negedge clk_i);
    end
    n_checks++;
    if (arv_seen !== 0 || lsu_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_misaligned_bus: arvalid cycles=%0d ready=%b want 0 1", arv_seen, lsu_ready_o);
    end
    issue(4'b1010, 32'h8000_0003, 32'h1111, 32'h0, 5'd8, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (lsu_err_o !== 1'b1 || lsu_awvalid_o !== 1'b0 || lsu_wvalid_o !== 1'b0 || lsu_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_misaligned: err=%b awv=%b wv=%b valid=%b want 1 0 0 1", lsu_err_o, lsu_awvalid_o, lsu_wvalid_o, lsu_valid_o);
    end
    idle(1);
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    wb_ready_i = 1'b0;
    issue(4'b0000, 32'h0, 32'h0, 32'h0000_CAFE, 5'd7, 1'b1);
    @(negedge clk_i);
    ex_op_i = 4'b0000; ex_result_i = 32'h0000_BEEF; ex_rd_i = 5'd9; ex_rd_wen_i = 1'b1;
    ex_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (lsu_ready_o !== 1'b0 || lsu_valid_o !== 1'b1 || lsu_data_o !== 32'h0000_CAFE || lsu_rd_o !== 5'd7) bad++;
      @(negedge clk_i);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d bad cycles, last ready=%b valid=%b data=%h rd=%0d want 0 1 cafe 7",
               bad, lsu_ready_o, lsu_valid_o, lsu_data_o, lsu_rd_o);
    end
    wb_ready_i = 1'b1;
    #1;
    n_checks++;
    if (lsu_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_drain_ready: got %b want 1", lsu_ready_o);
    end
    @(posedge clk_i); #1;
    ex_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b1 || lsu_data_o !== 32'h0000_BEEF || lsu_rd_o !== 5'd9) begin
      n_fail++;
      $display("FAIL backpressure_reload: valid=%b data=%h rd=%0d want 1 beef 9", lsu_valid_o, lsu_data_o, lsu_rd_o);
    end
    idle(1);
  endtask

  task automatic test_store_word_bresp;
    int bad;
    bad = 0;
    issue(4'b1011, 32'h8000_0010, 32'h1122_3344, 32'h0, 5'd4, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (lsu_awvalid_o !== 1'b1 || lsu_wvalid_o !== 1'b1 || lsu_wstrb_o !== 4'hF || lsu_wdata_o !== 32'h1122_3344) begin
      n_fail++;
      $display("FAIL sw_bus: awv=%b wv=%b wstrb=%h wdata=%h want 1 1 f 11223344", lsu_awvalid_o, lsu_wvalid_o, lsu_wstrb_o, lsu_wdata_o);
    end
    lsu_awready_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_awready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (lsu_awvalid_o !== 1'b0 || lsu_wvalid_o !== 1'b1 || lsu_bready_o !== 1'b0 || lsu_wdata_o !== 32'h1122_3344) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sw_w_hold: %0d bad cycles, last awv=%b wv=%b bready=%b want 0 1 0", bad, lsu_awvalid_o, lsu_wvalid_o, lsu_bready_o);
    end
    lsu_wready_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_wready_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_wvalid_o !== 1'b0 || lsu_bready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_b: wv=%b bready=%b want 0 1", lsu_wvalid_o, lsu_bready_o);
    end
    lsu_bresp_i = 2'b10; lsu_bvalid_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_bvalid_i = 1'b0; lsu_bresp_i = 2'b00;
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_rd_wen_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_bresp: valid=%b err=%b wen=%b want 1 1 0", lsu_valid_o, lsu_err_o, lsu_rd_wen_o);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    @(negedge clk_i);
    ex_op_i = 4'b0000; ex_result_i = 32'hA1; ex_rd_i = 5'd1; ex_rd_wen_i = 1'b1; ex_valid_i = 1'b1;
    @(posedge clk_i); #1;
    ex_result_i = 32'hB2; ex_rd_i = 5'd2; ex_rd_wen_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b1 || lsu_data_o !== 32'hA1 || fwd_valid_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b data=%h fwd=%b ready=%b want 1 a1 1 1", lsu_valid_o, lsu_data_o, fwd_valid_o, lsu_ready_o);
    end
    @(posedge clk_i); #1;
    ex_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b1 || lsu_data_o !== 32'hB2 || lsu_rd_o !== 5'd2 || fwd_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b data=%h rd=%0d fwd=%b want 1 b2 2 0", lsu_valid_o, lsu_data_o, lsu_rd_o, fwd_valid_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (lsu_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b want 0", lsu_valid_o);
    end
  endtask

  task automatic test_reset_mid;
    issue(4'b0011, 32'h8000_0020, 32'h0, 32'h0, 5'd6, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (lsu_arvalid_o !== 1'b0 || lsu_rready_o !== 1'b0 || lsu_valid_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: arvalid=%b rready=%b valid=%b ready=%b want 0 0 0 1",
               lsu_arvalid_o, lsu_rready_o, lsu_valid_o, lsu_ready_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; ex_valid_i = 1'b0; ex_op_i = 4'h0; ex_addr_i = '0; ex_wdata_i = '0;
    ex_result_i = '0; ex_rd_i = '0; ex_rd_wen_i = 1'b0; wb_ready_i = 1'b1;
    lsu_arready_i = 1'b0; lsu_rdata_i = '0; lsu_rvalid_i = 1'b0;
    lsu_awready_i = 1'b0; lsu_wready_i = 1'b0; lsu_bresp_i = 2'b00; lsu_bvalid_i = 1'b0;

    test_reset;
    test_passthrough;
    test_load("lb",  4'b0001, 32'h8000_0003, 32'h80FF_0000, 32'hFFFF_FF80);
    test_load("lbu", 4'b0100, 32'h8000_0003, 32'h80FF_0000, 32'h0000_0080);
    test_load("lh",  4'b0010, 32'h8000_0002, 32'h8001_1234, 32'hFFFF_8001);
    test_load("lhu", 4'b0101, 32'h8000_0002, 32'h8001_1234, 32'h0000_8001);
    test_load("lw",  4'b0011, 32'h8000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D);
    test_store_half;
    test_store_byte;
    test_misaligned;
    test_backpressure;
    test_store_word_bresp;
    test_back_to_back;
    test_reset_mid;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
